// File: rtl/md_exec_unit.sv
// rtl/md_exec_unit.sv - iterative RV32M multiply/divide execution unit
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   op_valid issuer requests an operation (sampled only in IDLE)
//   op_sel   5'b10000..5'b10111 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1      operand A (multiplicand / dividend)
//   rs2      operand B (multiplier / divisor)
//   busy     high while in CALC or FIX
//   done     one-cycle pulse in DONE, result valid
//   result   registered result, updated only on entry to DONE
module md_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [4:0]  op_sel,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state_q,  state_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [2:0]  op_q,     op_d;      // op_sel[2:0]; [4:3] is fixed at acceptance
    logic        neg_a_q,  neg_a_d;   // rs1 negative under this op's signedness
    logic        neg_b_q,  neg_b_d;
    logic [31:0] opa_q,    opa_d;     // multiplicand magnitude or divisor magnitude
    logic [63:0] prod_q,   prod_d;    // mul: {partial hi, multiplier}; div: {rem, dividend/quotient}
    logic [31:0] result_q, result_d;

    // Operand decode, used only at acceptance
    logic        acc_ok;
    logic        in_div;
    logic        in_sa, in_sb;
    logic        in_na, in_nb;
    logic [31:0] mag_a, mag_b;
    logic        div_zero, div_ovf;

    // Iteration datapath
    logic [32:0] mul_sum;
    logic [32:0] div_tmp;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] mul_step, div_step;

    // Sign fix-up
    logic [63:0] prod_neg;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] fix_res;

    always_comb begin
        acc_ok   = op_valid && (op_sel[4:3] == 2'b10);
        in_div   = op_sel[2];
        // MULH: both signed; MULHSU: rs1 signed; DIV/REM: both signed
        in_sa    = in_div ? ~op_sel[0] : (op_sel[1:0] == 2'b01 || op_sel[1:0] == 2'b10);
        in_sb    = in_div ? ~op_sel[0] : (op_sel[1:0] == 2'b01);
        in_na    = in_sa & rs1[31];
        in_nb    = in_sb & rs2[31];
        mag_a    = in_na ? (32'd0 - rs1) : rs1;
        mag_b    = in_nb ? (32'd0 - rs2) : rs2;
        div_zero = in_div && (rs2 == 32'd0);
        div_ovf  = in_div && !op_sel[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

        // Shift-add: add multiplicand into upper half on multiplier LSB, then shift right
        mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opa_q} : 33'd0);
        mul_step = {mul_sum, prod_q[31:1]};

        // Restoring divide: shift next dividend bit into remainder, subtract if it fits
        div_tmp  = prod_q[63:31];
        div_ge   = div_tmp >= {1'b0, opa_q};
        div_sub  = div_tmp[31:0] - opa_q;
        div_step = {(div_ge ? div_sub : div_tmp[31:0]), prod_q[30:0], div_ge};

        prod_neg = 64'd0 - prod_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? (32'd0 - prod_q[31:0]) : prod_q[31:0];
        rem_fix  = neg_a_q ? (32'd0 - prod_q[63:32]) : prod_q[63:32];
        if (op_q[2]) begin
            fix_res = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q[1:0] == 2'b00) begin
            fix_res = prod_q[31:0];   // low half identical with or without negation for MUL
        end else begin
            fix_res = (neg_a_q ^ neg_b_q) ? prod_neg[63:32] : prod_q[63:32];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        opa_d    = opa_q;
        prod_d   = prod_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (acc_ok) begin
                    op_d    = op_sel[2:0];
                    neg_a_d = in_na;
                    neg_b_d = in_nb;
                    cnt_d   = 5'd0;
                    opa_d   = in_div ? mag_b : mag_a;
                    prod_d  = {32'd0, (in_div ? mag_a : mag_b)};
                    if (div_zero) begin
                        state_d  = DONE;
                        result_d = op_sel[1] ? rs1 : 32'hFFFF_FFFF;
                    end else if (div_ovf) begin
                        state_d  = DONE;
                        result_d = op_sel[1] ? 32'd0 : 32'h8000_0000;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                prod_d = op_q[2] ? div_step : mul_step;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opa_q    <= 32'd0;
            prod_q   <= 64'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            opa_q    <= opa_d;
            prod_q   <= prod_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_md_exec_unit.sv
// tb/tb_md_exec_unit.sv - directed self-checking bench for md_exec_unit
module tb_md_exec_unit;

    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [4:0]  op_sel;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks;
    int n_fails;

    md_exec_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_sel   (op_sel),
        .rs1      (rs1),
        .rs2      (rs2),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it to done. exp_lat counts cycles after the
    // acceptance edge; busy is expected for 33 cycles on the iterative path, 0 on bypass.
    task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input bit toggle);
        int n;
        int busy_cnt;
        bit overlap;
        @(negedge clk);
        op_valid = 1'b1;
        op_sel   = sel;
        rs1      = a;
        rs2      = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        n        = 1;
        busy_cnt = 0;
        overlap  = 1'b0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            if (toggle) begin
                rs1    = $urandom;
                rs2    = $urandom;
                op_sel = 5'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (busy && done) overlap = 1'b1;
        check({tag, " done_latency"}, 32'(n), 32'(exp_lat));
        check({tag, " result"}, result, exp);
        check({tag, " busy_cycles"}, 32'(busy_cnt), (exp_lat == 1) ? 32'd0 : 32'd33);
        check({tag, " busy_with_done"}, {31'd0, overlap}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, " result_hold"}, result, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_sel   = 5'd0;
        rs1      = 32'd0;
        rs2      = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   {31'd0, busy}, 32'd0);
        check("reset done",   {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-M op_sel ignored
        op_valid = 1'b1;
        op_sel   = 5'b00001;
        rs1      = 32'd9;
        rs2      = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("invalid_op busy", {31'd0, busy}, 32'd0);
            check("invalid_op done", {31'd0, done}, 32'd0);
        end
        op_valid = 1'b0;

        run_op("MUL 7*-3",       OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0);
        run_op("MULHU -1*-1",    OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
        run_op("MULH -1*-1",     OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34, 1'b0);
        run_op("MULHSU -1*-1",   OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("DIV -7/2",       OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 1'b0);
        run_op("REM -7/2",       OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 1'b0);
        run_op("DIVU 100/7",     OP_DIVU,   32'd100,        32'd7,         32'd14,        34, 1'b0);
        run_op("REMU 100/7",     OP_REMU,   32'd100,        32'd7,         32'd2,         34, 1'b0);
        run_op("DIV 5/0",        OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1,  1'b0);
        run_op("REMU 5/0",       OP_REMU,   32'd5,          32'd0,         32'd5,         1,  1'b0);
        run_op("DIV ovf",        OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
        run_op("REM ovf",        OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  1'b0);
        run_op("DIVU toggled",   OP_DIVU,   32'd1000,       32'd3,         32'd333,       34, 1'b1);
        run_op("MUL toggled",    OP_MUL,    32'd123,        32'd456,       32'd56088,     34, 1'b1);

        // Reset pulsed mid-operation
        @(negedge clk);
        op_valid = 1'b1;
        op_sel   = OP_DIVU;
        rs1      = 32'd100;
        rs2      = 32'd7;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("midop busy before reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midop reset busy",   {31'd0, busy}, 32'd0);
        check("midop reset done",   {31'd0, done}, 32'd0);
        check("midop reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen_done;
            seen_done = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (done || busy) seen_done++;
            end
            check("midop no done after reset", 32'(seen_done), 32'd0);
        end
        run_op("MUL 3*4 after reset", OP_MUL, 32'd3, 32'd4, 32'd12, 34, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
